apuf_race_ctrl: RTL and testbench



---
 rtl/apuf_pkg.sv | 32 +++
 rtl/apuf_race_ctrl_if.sv | 31 +++
 rtl/apuf_sync2.sv | 24 ++
 rtl/apuf_race_ctrl.sv | 132 +++++++++++++
 tb/tb_apuf_race_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF race controller: FSM encoding,
// parameter defaults and a constant-safe clog2 helper.
package apuf_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_ARM    = 3'd2,
      S_FIRE   = 3'd3,
      S_SAMPLE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam int DEF_N_STAGES   = 64;
   localparam int DEF_SETTLE_CYC = 8;
   localparam int DEF_N_REPEAT   = 15;
   localparam int DEF_CNT_W      = 8;

   // Number of bits needed to encode value-1; clog2(1) is 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/apuf_race_ctrl_if.sv
// Request/response side of the race controller. The soft_resp member and the
// CNT_W parameter exist only when APUF_SOFT_RESP_EN is defined.
interface apuf_race_ctrl_if #(
   parameter int N_STAGES = 64
`ifdef APUF_SOFT_RESP_EN
   , parameter int CNT_W  = 8
`endif
);

   // Handshake: start is a request that is only honoured while busy is low;
   // the accept edge is the first clock edge with start=1 and busy=0. The
   // result is marked by a single-cycle valid pulse, coincident with busy
   // falling; resp stays valid until the next pulse.
   logic                start;
   logic [N_STAGES-1:0] chal_in;
   logic                busy;
   logic                resp;
   logic                valid;
`ifdef APUF_SOFT_RESP_EN
   logic [CNT_W-1:0]    soft_resp;
`endif

`ifdef APUF_SOFT_RESP_EN
   modport master (output start, chal_in, input busy, resp, valid, soft_resp);
   modport slave  (input start, chal_in, output busy, resp, valid, soft_resp);
`else
   modport master (output start, chal_in, input busy, resp, valid);
   modport slave  (input start, chal_in, output busy, resp, valid);
`endif

endinterface

// File: rtl/apuf_sync2.sv
// Two-flop synchroniser bringing the asynchronous arbiter output into clk.
module apuf_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic meta;
   (* ASYNC_REG = "TRUE" *) logic sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= d;
         sync <= meta;
      end
   end

   assign q = sync;

endmodule

// File: rtl/apuf_race_ctrl.sv
// Launch/sample controller for one arbiter-PUF chain: runs N_REPEAT races per
// challenge and majority-votes them. Optional soft_resp under APUF_SOFT_RESP_EN.
module apuf_race_ctrl
   import apuf_pkg::*;
#(
   parameter int N_STAGES   = DEF_N_STAGES,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int N_REPEAT   = DEF_N_REPEAT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   apuf_race_ctrl_if.slave     bus,
   output logic [N_STAGES-1:0] chal_o,
   output logic                launch,
   input  logic                arb_q,
   output state_t              fsm_state
);

   if (N_REPEAT < 1 || N_REPEAT > 255 || (N_REPEAT % 2) == 0) begin : g_bad_repeat
      $error("apuf_race_ctrl: N_REPEAT must be odd and within 1..255");
   end
   if (SETTLE_CYC < 2 || SETTLE_CYC > 255) begin : g_bad_settle
      $error("apuf_race_ctrl: SETTLE_CYC must be within 2..255");
   end
   if (CNT_W < clog2(N_REPEAT + 1)) begin : g_bad_cnt_w
      $error("apuf_race_ctrl: CNT_W too narrow for N_REPEAT");
   end

   // FIRE lasts SETTLE_CYC+2 cycles, so the phase timer needs 9 bits at 255.
   localparam logic [8:0]       ARM_LAST  = 9'(SETTLE_CYC - 1);
   localparam logic [8:0]       FIRE_LAST = 9'(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(N_REPEAT - 1);
   localparam logic [CNT_W-1:0] HALF      = CNT_W'(N_REPEAT / 2);

   state_t              state;
   logic [8:0]          timer;
   logic [CNT_W-1:0]    rep;
   logic [CNT_W-1:0]    ones;
   logic                arb_s;
   logic                busy_r;
   logic                resp_r;
   logic                valid_r;
`ifdef APUF_SOFT_RESP_EN
   logic [CNT_W-1:0]    soft_r;
`endif

   apuf_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (arb_q),
      .q   (arb_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         timer   <= '0;
         rep     <= '0;
         ones    <= '0;
         chal_o  <= '0;
         launch  <= 1'b0;
         busy_r  <= 1'b0;
         resp_r  <= 1'b0;
         valid_r <= 1'b0;
`ifdef APUF_SOFT_RESP_EN
         soft_r  <= '0;
`endif
      end else begin
         valid_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  chal_o <= bus.chal_in;
                  busy_r <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               rep   <= '0;
               ones  <= '0;
               timer <= '0;
               state <= S_ARM;
            end
            S_ARM: begin
               if (timer == ARM_LAST) begin
                  timer  <= '0;
                  launch <= 1'b1;
                  state  <= S_FIRE;
               end else begin
                  timer <= timer + 9'd1;
               end
            end
            S_FIRE: begin
               if (timer == FIRE_LAST) begin
                  timer <= '0;
                  state <= S_SAMPLE;
               end else begin
                  timer <= timer + 9'd1;
               end
            end
            S_SAMPLE: begin
               // launch was high through this cycle; drop it on the way out.
               ones   <= ones + {{(CNT_W-1){1'b0}}, arb_s};
               rep    <= rep + {{(CNT_W-1){1'b0}}, 1'b1};
               launch <= 1'b0;
               state  <= (rep == REP_LAST) ? S_DONE : S_ARM;
            end
            S_DONE: begin
               resp_r  <= (ones > HALF);
               valid_r <= 1'b1;
               busy_r  <= 1'b0;
               launch  <= 1'b0;
`ifdef APUF_SOFT_RESP_EN
               soft_r  <= ones;
`endif
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.resp  = resp_r;
   assign bus.valid = valid_r;
`ifdef APUF_SOFT_RESP_EN
   assign bus.soft_resp = soft_r;
`endif
   assign fsm_state = state;

endmodule

// File: tb/tb_apuf_race_ctrl.sv
// Bench for apuf_race_ctrl (N_REPEAT=5, SETTLE_CYC=4): vector table plus
// hand sequences for busy-start, mid-run reset and back-to-back evaluation.
module tb_apuf_race_ctrl;
   import apuf_pkg::*;

   localparam int N_STAGES = 64;
   localparam int SETTLE   = 4;
   localparam int N_REP    = 5;
   localparam int CNT_W    = 8;
   localparam int LAT      = 1 + N_REP * (2 * SETTLE + 3) + 1;

   typedef struct {
      logic [63:0]      chal;
      logic [15:0]      pat;
      int               poke_at;
      logic             exp_resp;
      logic [CNT_W-1:0] exp_ones;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [N_STAGES-1:0] chal_o;
   logic                launch;
   logic                arb_q = 1'b0;
   state_t              fsm_state;

   int n_vec = 0;
   int n_err = 0;
   logic [CNT_W:0] exp_q[$];

   int          race_idx  = 0;
   int          race_base = 0;
   logic [15:0] race_pat  = '0;

   vec_t vecs[8];

`ifdef APUF_SOFT_RESP_EN
   apuf_race_ctrl_if #(.N_STAGES(N_STAGES), .CNT_W(CNT_W)) bus ();
`else
   apuf_race_ctrl_if #(.N_STAGES(N_STAGES)) bus ();
`endif

   apuf_race_ctrl #(
      .N_STAGES   (N_STAGES),
      .SETTLE_CYC (SETTLE),
      .N_REPEAT   (N_REP),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .chal_o    (chal_o),
      .launch    (launch),
      .arb_q     (arb_q),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   // Arbiter model: settles a few ns after each launch edge, off the clock grid.
   always @(launch) begin
      int off;
      if (launch === 1'b1) begin
         #3;
         off   = race_idx - race_base;
         arb_q = (off >= 0 && off < 16) ? race_pat[off] : 1'b0;
      end else begin
         #3;
         arb_q    = 1'b0;
         race_idx = race_idx + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [CNT_W:0] model(input logic [15:0] pat);
      logic [4:0]       p;
      logic [CNT_W-1:0] ones;
      p    = pat[4:0];
      ones = CNT_W'($countones(p));
      return {(ones > CNT_W'(N_REP / 2)), ones};
   endfunction

   always @(negedge clk) begin : mon
      logic [CNT_W:0] e;
      if (rst === 1'b0 && bus.valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got valid=1, expected no result pending (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            check("resp", 64'(bus.resp), 64'(e[CNT_W]));
`ifdef APUF_SOFT_RESP_EN
            check("soft_resp", 64'(bus.soft_resp), 64'(e[CNT_W-1:0]));
`endif
         end
      end
   end

   task automatic run_eval(input vec_t v);
      int   got_lat;
      int   chal_bad;
      int   rises;
      int   run_len;
      int   high_len;
      int   low_len;
      logic prev_l;
      @(negedge clk);
      race_base   = race_idx;
      race_pat    = v.pat;
      bus.chal_in = v.chal;
      bus.start   = 1'b1;
      exp_q.push_back({v.exp_resp, v.exp_ones});
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_accept", 64'(bus.busy), 64'd1);
      check("chal_o_capture", chal_o, v.chal);
      got_lat  = 0;
      chal_bad = 0;
      rises    = 0;
      run_len  = 1;
      high_len = 0;
      low_len  = 0;
      prev_l   = launch;
      for (int k = 1; k <= LAT + 20 && got_lat == 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (chal_o !== v.chal) chal_bad++;
         if (launch !== prev_l) begin
            if (prev_l === 1'b1 && high_len == 0) high_len = run_len;
            if (prev_l === 1'b0 && rises == 1 && low_len == 0) low_len = run_len;
            if (launch === 1'b1) rises++;
            run_len = 1;
         end else begin
            run_len++;
         end
         prev_l = launch;
         if (bus.valid === 1'b1) begin
            got_lat = k;
            check("busy_at_valid", 64'(bus.busy), 64'd0);
            check("launch_at_valid", 64'(launch), 64'd0);
         end
         if (k == v.poke_at) begin
            bus.start   = 1'b1;
            bus.chal_in = ~v.chal;
         end else if (k == v.poke_at + 1) begin
            bus.start   = 1'b0;
            bus.chal_in = v.chal;
         end
      end
      check("valid_latency", 64'(got_lat), 64'(LAT));
      check("chal_o_stable", 64'(chal_bad), 64'd0);
      check("launch_pulses", 64'(rises), 64'(N_REP));
      check("launch_high_len", 64'(high_len), 64'(SETTLE + 3));
      check("launch_low_len", 64'(low_len), 64'(SETTLE));
      repeat (3) @(negedge clk);
      check("resp_hold", 64'(bus.resp), 64'(v.exp_resp));
      check("idle_busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int          vcount;
      int          v1;
      int          v2;
      logic [63:0] c;
      logic [CNT_W:0] m;

      vecs[0] = '{64'hA5A5_0000_FFFF_1234, 16'h001F, 0, 1'b1, 8'd5};
      vecs[1] = '{64'h0123_4567_89AB_CDEF, 16'h0015, 0, 1'b1, 8'd3};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'h0003, 0, 1'b0, 8'd2};
      vecs[3] = '{64'h8000_0000_0000_0001, 16'h0000, 0, 1'b0, 8'd0};
      vecs[4] = '{64'h0F0F_F0F0_3C3C_C3C3, 16'h000E, 20, 1'b1, 8'd3};
      vecs[5] = '{64'hDEAD_BEEF_0BAD_F00D, 16'h0010, 0, 1'b0, 8'd1};
      for (int i = 6; i < 8; i++) begin
         vecs[i].chal    = {$urandom, $urandom};
         vecs[i].pat     = 16'($urandom_range(0, 31));
         vecs[i].poke_at = 0;
         m               = model(vecs[i].pat);
         vecs[i].exp_resp = m[CNT_W];
         vecs[i].exp_ones = m[CNT_W-1:0];
      end

      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.chal_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_chal_o", chal_o, 64'd0);
      check("rst_launch", 64'(launch), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_resp", 64'(bus.resp), 64'd0);
      check("rst_valid", 64'(bus.valid), 64'd0);
      check("rst_state", 64'(fsm_state), 64'(S_IDLE));
`ifdef APUF_SOFT_RESP_EN
      check("rst_soft_resp", 64'(bus.soft_resp), 64'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_eval(vecs[i]);

      // Reset in the middle of a race: everything drops, no result appears.
      @(negedge clk);
      race_base   = race_idx;
      race_pat    = 16'h001F;
      bus.chal_in = 64'h1111_2222_3333_4444;
      bus.start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (29) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_abort_launch", 64'(launch), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_launch", 64'(launch), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_chal_o", chal_o, 64'd0);
      check("abort_state", 64'(fsm_state), 64'(S_IDLE));
      rst    = 1'b0;
      vcount = 0;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (bus.valid === 1'b1) vcount++;
      end
      check("abort_no_valid", 64'(vcount), 64'd0);
      run_eval(vecs[0]);

      // start held high: second accept lands in the IDLE cycle after DONE.
      c = 64'h5A5A_A5A5_1234_8765;
      @(negedge clk);
      race_base   = race_idx;
      race_pat    = 16'hFFFF;
      bus.chal_in = c;
      bus.start   = 1'b1;
      exp_q.push_back({1'b1, 8'd5});
      exp_q.push_back({1'b1, 8'd5});
      @(posedge clk);
      v1     = 0;
      v2     = 0;
      vcount = 0;
      for (int k = 1; k <= 2 * LAT + 30 && v2 == 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.valid === 1'b1) begin
            vcount++;
            if (v1 == 0) v1 = k;
            else v2 = k;
         end
         if (k == LAT + 1) begin
            check("b2b_reaccept_busy", 64'(bus.busy), 64'd1);
            check("b2b_chal_o", chal_o, c);
            bus.start = 1'b0;
         end
      end
      check("b2b_first_valid", 64'(v1), 64'(LAT));
      check("b2b_second_valid", 64'(v2), 64'(2 * LAT + 1));
      check("b2b_valid_count", 64'(vcount), 64'd2);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
